// File: rtl/soc2_ram_rd_pkg.sv
// Shared definitions for the RAM-to-stream reader: FSM encoding, default widths
// and the fixed read latency of the on-chip RAM slave.
package soc2_ram_rd_pkg;

    localparam int RAM_AW_DEF   = 9;
    localparam int DATA_W_DEF   = 32;
    localparam int READ_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/soc2_ram_rd_fifo.sv
// Show-ahead output buffer: the head word is presented on rdata_o whenever the
// buffer is non-empty, and reads back as zero while empty.
module soc2_ram_rd_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o,
    output logic [PW:0]   count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && (count_q < (PW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/soc2_ram_stream_reader.sv
// Avalon-MM read master that copies a run of on-chip RAM words into an Avalon-ST
// packet, with reads throttled so every returning word has a FIFO slot.
module soc2_ram_stream_reader
    import soc2_ram_rd_pkg::*;
#(
    parameter int RAM_AW     = RAM_AW_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [RAM_AW-1:0]   src_addr,
    input  logic [RAM_AW:0]     length,
    output logic                busy,
    output logic                done,
    output logic [RAM_AW-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready,
    output logic                src_startofpacket,
    output logic                src_endofpacket,
    output logic [1:0]          dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // Stream handshake: a beat moves when src_valid && src_ready; while src_valid
    // is high and src_ready low, src_data and src_valid hold their values.

    rd_state_e                state_q, state_d;
    logic [RAM_AW-1:0]        addr_q, addr_d;
    logic [RAM_AW:0]          len_q, len_d;
    logic [RAM_AW:0]          rd_cnt_q, rd_cnt_d;
    logic [RAM_AW:0]          beat_cnt_q, beat_cnt_d;
    logic [READ_LATENCY-1:0]  inflight_q, inflight_d;
    logic                     done_q;

    logic                     issue;
    logic                     pop;
    logic                     fifo_empty;
    logic [PW:0]              fifo_count;
    logic [PW+1:0]            inflight_cnt;
    logic [PW+1:0]            occ;

    assign ram_write      = 1'b0;
    assign ram_byteenable = '1;
    assign ram_clken      = 1'b1;
    assign ram_address    = addr_q;
    assign ram_chipselect = issue;

    assign src_valid         = !fifo_empty;
    assign pop               = src_valid && src_ready;
    assign src_startofpacket = src_valid && (beat_cnt_q == '0);
    assign src_endofpacket   = src_valid && (beat_cnt_q == len_q - (RAM_AW+1)'(1));

    assign busy      = (state_q != ST_IDLE) || done_q;
    assign done      = done_q;
    assign dbg_state = state_q;

    soc2_ram_rd_fifo #(
        .DW    (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (inflight_q[READ_LATENCY-1]),
        .wdata_i (ram_readdata),
        .pop_i   (pop),
        .rdata_o (src_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + (PW+2)'(inflight_q[i]);
        end
        occ = (PW+2)'(fifo_count) + inflight_cnt;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        issue      = 1'b0;

        if (pop) begin
            beat_cnt_d = beat_cnt_q + (RAM_AW+1)'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // done_q high here means DONE just ended; a start now is dropped.
                if (start && !done_q) begin
                    addr_d     = src_addr;
                    len_d      = length;
                    rd_cnt_d   = '0;
                    beat_cnt_d = '0;
                    state_d    = (length == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (occ < (PW+2)'(FIFO_DEPTH)) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + RAM_AW'(1);
                    rd_cnt_d = rd_cnt_q + (RAM_AW+1)'(1);
                    if (rd_cnt_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave once the last buffered word is leaving and nothing is returning.
                if ((inflight_cnt == '0) &&
                    ((fifo_count == '0) || ((fifo_count == (PW+1)'(1)) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        inflight_d    = inflight_q << 1;
        inflight_d[0] = issue;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= inflight_d;
            done_q     <= (state_q == ST_DONE);
        end
    end

endmodule

// File: tb/tb_soc2_ram_stream_reader.sv
// Directed bench for soc2_ram_stream_reader: RAM model with one-cycle read latency,
// stream monitor with expected-word queue, and per-scenario timing checks.
module tb_soc2_ram_stream_reader;

    localparam int RAM_AW = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [RAM_AW-1:0]   src_addr;
    logic [RAM_AW:0]     length;
    logic                busy;
    logic                done;
    logic [RAM_AW-1:0]   ram_address;
    logic                ram_chipselect;
    logic                ram_write;
    logic [DATA_W/8-1:0] ram_byteenable;
    logic                ram_clken;
    logic [DATA_W-1:0]   ram_readdata;
    logic [DATA_W-1:0]   src_data;
    logic                src_valid;
    logic                src_ready;
    logic                src_startofpacket;
    logic                src_endofpacket;
    logic [1:0]          dbg_state;

    soc2_ram_stream_reader #(
        .RAM_AW(RAM_AW), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .src_addr          (src_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .ram_address       (ram_address),
        .ram_chipselect    (ram_chipselect),
        .ram_write         (ram_write),
        .ram_byteenable    (ram_byteenable),
        .ram_clken         (ram_clken),
        .ram_readdata      (ram_readdata),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
        .dbg_state         (dbg_state)
    );

    // clock / reset
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // RAM model, one-cycle read latency
    logic [DATA_W-1:0] mem [512];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 + i;
        ram_readdata = '0;
    end
    always @(posedge clk) if (ram_chipselect) ram_readdata <= mem[ram_address];

    // scoreboard state
    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    int exp_len, beat_idx, beat_cnt, cs_cnt, done_cnt;
    int first_cs, first_valid, last_beat, done_cyc;
    int issued, popped;
    logic busy_at_done;
    logic prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic rnd_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_mon();
        exp_q.delete();
        beat_idx = 0; beat_cnt = 0; cs_cnt = 0; done_cnt = 0;
        first_cs = -1; first_valid = -1; last_beat = -1; done_cyc = -1;
        issued = 0; popped = 0; busy_at_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    endtask

    // monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, src_valid}, 32'd1);
                chk("hold_data", src_data, prev_data);
            end
            if (ram_chipselect) begin
                if (first_cs < 0) first_cs = cyc;
                cs_cnt++;
                chk("occ_limit", {31'b0, (issued - popped) < DEPTH}, 32'd1);
                issued++;
            end
            if (src_valid && first_valid < 0) first_valid = cyc;
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", src_data, 32'hFFFF_FFFF);
                end else begin
                    chk("beat_data", src_data, exp_q.pop_front());
                    chk("sop", {31'b0, src_startofpacket}, {31'b0, beat_idx == 0});
                    chk("eop", {31'b0, src_endofpacket}, {31'b0, beat_idx == exp_len - 1});
                end
                beat_idx++; beat_cnt++; popped++;
                last_beat = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            prev_stall = src_valid && !src_ready;
            prev_data  = src_data;
        end
    end

    // background ready toggler
    always @(posedge clk) begin
        #1;
        if (rnd_mode) src_ready = 1'($urandom_range(0, 1));
    end

    // driver: start in cycle s, wait bounded for done
    task automatic run_xfer(input logic [RAM_AW-1:0] a, input logic [RAM_AW:0] n,
                            input logic rnd, output int s);
        clear_mon();
        exp_len = int'(n);
        for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[(int'(a) + i) % 512]);
        rnd_mode  = rnd;
        src_ready = 1'b1;
        src_addr  = a;
        length    = n;
        start     = 1'b1;
        s         = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 6000 && done_cnt == 0; k++) @(posedge clk);
        #1;
        rnd_mode  = 1'b0;
        src_ready = 1'b1;
        chk("done_seen", {31'b0, done_cnt > 0}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("beat_count", beat_cnt, int'(n));
        chk("exp_q_left", exp_q.size(), 0);
        chk("done_once", done_cnt, 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_valid"}, {31'b0, src_valid}, 32'd0);
        chk({tag, "_sop_eop"}, {30'b0, src_startofpacket, src_endofpacket}, 32'd0);
        chk({tag, "_cs"}, {31'b0, ram_chipselect}, 32'd0);
        chk({tag, "_addr"}, {23'b0, ram_address}, 32'd0);
        chk({tag, "_data"}, src_data, 32'd0);
        chk({tag, "_state"}, {30'b0, dbg_state}, 32'd0);
    endtask

    int s;

    initial begin
        reset_n = 1'b0; start = 1'b0; src_addr = '0; length = '0; src_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        chk_idle_outputs("rst");
        chk("ram_write", {31'b0, ram_write}, 32'd0);
        chk("ram_be", {28'b0, ram_byteenable}, 32'hF);
        chk("ram_clken", {31'b0, ram_clken}, 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // basic 8-word transfer, ready always high
        run_xfer(9'h010, 10'd8, 1'b0, s);
        chk("t1_first_cs", first_cs - s, 1);
        chk("t1_first_valid", first_valid - s, 3);
        chk("t1_back_to_back", last_beat - first_valid, 7);
        chk("t1_done_gap_ok", {31'b0, (done_cyc - last_beat) >= 1 && (done_cyc - last_beat) <= 2}, 32'd1);
        chk("t1_busy_at_done", {31'b0, busy_at_done}, 32'd1);
        chk("t1_busy_after", {31'b0, busy}, 32'd0);

        // address wrap 0x1FE..0x001
        run_xfer(9'h1FE, 10'd4, 1'b0, s);

        // zero length, then a start coinciding with done is dropped
        clear_mon();
        src_addr = 9'h055; length = 10'd0; start = 1'b1; s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        length = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("t3_done_cyc", done_cyc - s, 2);
        chk("t3_done_once", done_cnt, 1);
        chk("t3_no_cs", cs_cnt, 0);
        chk("t3_no_valid", beat_cnt, 0);
        chk("t3_busy_after", {31'b0, busy}, 32'd0);

        // 64 words with random backpressure
        run_xfer(9'h020, 10'd64, 1'b1, s);

        // single beat, second start while busy ignored
        clear_mon();
        exp_len = 1;
        exp_q.push_back(mem[9'h0AA]);
        src_addr = 9'h0AA; length = 10'd1; start = 1'b1; s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("t5_busy", {31'b0, busy}, 32'd1);
        src_addr = 9'h100; length = 10'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk); #1;
        chk("t5_beats", beat_cnt, 1);
        chk("t5_cs", cs_cnt, 1);
        chk("t5_done_once", done_cnt, 1);

        // long transfer re-reading wrapped addresses
        run_xfer(9'h1FE, 10'd516, 1'b0, s);

        // reset at beat 5 of 20, then fresh transfer
        clear_mon();
        exp_len = 20;
        for (int i = 0; i < 20; i++) exp_q.push_back(mem[9'h040 + i]);
        src_addr = 9'h040; length = 10'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && beat_cnt < 5; k++) @(posedge clk);
        #1;
        chk("t6_reached_beat5", beat_cnt, 5);
        reset_n = 1'b0;
        chk_idle_outputs("t6_rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_idle_outputs("t6_post");
        repeat (10) @(posedge clk); #1;
        chk("t6_no_done", done_cnt, 0);
        run_xfer(9'h0C0, 10'd3, 1'b0, s);
        chk("t6_fresh_first_valid", first_valid - s, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
